// File: rtl/packet_read_align_pkg.sv
// Shared size codes, FSM state encoding and small helpers for the packet read stage.
package packet_read_align_pkg;

    localparam logic [1:0] PKT_SZ_B = 2'b00;
    localparam logic [1:0] PKT_SZ_H = 2'b01;
    localparam logic [1:0] PKT_SZ_W = 2'b10;

    typedef enum logic [1:0] {
        PRA_IDLE = 2'd0,
        PRA_RD0  = 2'd1,
        PRA_RD1  = 2'd2
    } pra_state_e;

    // Size code 11 behaves as a word everywhere.
    function automatic logic is_straddle(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            PKT_SZ_B: return 1'b0;
            PKT_SZ_H: return (offset == 2'd3);
            default:  return (offset != 2'd0);
        endcase
    endfunction

    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            PKT_SZ_B: return 3'd1;
            PKT_SZ_H: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/packet_read_align_extract.sv
// Combinational big-endian byte extraction: shift {w0,w1} left by the byte offset,
// keep the top 1/2/4 bytes and zero-extend to 32 bits.
module packet_byte_extract
    import packet_read_align_pkg::*;
(
    input  logic [63:0] words_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    output logic [31:0] result_o
);

    logic [63:0] shifted;

    assign shifted = words_i << {offset_i, 3'b000};

    always_comb begin
        result_o = 32'h0;
        case (size_i)
            PKT_SZ_B: result_o = {24'h0, shifted[63:56]};
            PKT_SZ_H: result_o = {16'h0, shifted[63:48]};
            default:  result_o = shifted[63:32];
        endcase
    end

endmodule

// File: rtl/packet_read_align.sv
// Byte-addressed packet buffer read stage with straddle handling.
// Optional bounds check against packet_len when PACKET_BOUNDS_CHECK_EN is defined.
module packet_read_align
    import packet_read_align_pkg::*;
#(
    parameter int BYTE_ADDR_WIDTH = 12,
    parameter int PLEN_WIDTH      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_en,
    input  logic [BYTE_ADDR_WIDTH-1:0]   rd_addr,
    input  logic [1:0]                   rd_size,
    input  logic [PLEN_WIDTH-1:0]        packet_len,
    output logic                         busy,
    output logic                         mem_rd_en,
    output logic [BYTE_ADDR_WIDTH-3:0]   mem_addr,
    input  logic [31:0]                  mem_rdata,
    output logic [31:0]                  packet_data,
    output logic                         data_vld,
    output logic                         oob
);

    localparam int WAW = BYTE_ADDR_WIDTH - 2;
    localparam int EW  = PLEN_WIDTH + 1;

    pra_state_e      state_q, state_d;
    logic [1:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic [WAW-1:0]  waddr_q, waddr_d;
    logic [31:0]     w0_q, w0_d;
    logic [31:0]     data_q, data_d;
    logic            vld_q, vld_d;
    logic            oob_q, oob_d;

    logic            accept;
    logic            req_oob;
    logic [63:0]     ext_words;
    logic [31:0]     ext_result;

    assign accept = rd_en && (state_q == PRA_IDLE);

`ifdef PACKET_BOUNDS_CHECK_EN
    logic [EW-1:0] end_addr;
    assign end_addr = EW'(rd_addr) + EW'(size_nbytes(rd_size));
    assign req_oob  = (end_addr > {1'b0, packet_len});
`else
    logic unused_plen;
    assign unused_plen = ^packet_len;
    assign req_oob     = 1'b0;
`endif

    // Second word only exists in RD1; otherwise the low half is zero.
    assign ext_words = (state_q == PRA_RD1) ? {w0_q, mem_rdata} : {mem_rdata, 32'h0};

    packet_byte_extract u_extract (
        .words_i  (ext_words),
        .offset_i (off_q),
        .size_i   (size_q),
        .result_o (ext_result)
    );

    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        size_d    = size_q;
        waddr_d   = waddr_q;
        w0_d      = w0_q;
        data_d    = data_q;
        vld_d     = 1'b0;
        oob_d     = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;

        case (state_q)
            PRA_IDLE: begin
                if (accept) begin
                    off_d   = rd_addr[1:0];
                    size_d  = rd_size;
                    waddr_d = rd_addr[BYTE_ADDR_WIDTH-1:2];
                    state_d = PRA_RD0;
                    // Out-of-bounds requests answer one cycle early without touching memory.
                    if (req_oob) begin
                        data_d = 32'h0;
                        vld_d  = 1'b1;
                        oob_d  = 1'b1;
                    end else begin
                        mem_rd_en = 1'b1;
                        mem_addr  = rd_addr[BYTE_ADDR_WIDTH-1:2];
                    end
                end
            end
            PRA_RD0: begin
                if (oob_q) begin
                    state_d = PRA_IDLE;
                end else if (is_straddle(size_q, off_q)) begin
                    w0_d      = mem_rdata;
                    mem_rd_en = 1'b1;
                    mem_addr  = waddr_q + WAW'(1);
                    state_d   = PRA_RD1;
                end else begin
                    data_d  = ext_result;
                    vld_d   = 1'b1;
                    state_d = PRA_IDLE;
                end
            end
            PRA_RD1: begin
                data_d  = ext_result;
                vld_d   = 1'b1;
                state_d = PRA_IDLE;
            end
            default: state_d = PRA_IDLE;
        endcase

        if (rst) begin
            mem_rd_en = 1'b0;
            mem_addr  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRA_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            off_q   <= 2'd0;
            size_q  <= PKT_SZ_B;
            waddr_q <= '0;
            w0_q    <= 32'h0;
            data_q  <= 32'h0;
            vld_q   <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            off_q   <= off_d;
            size_q  <= size_d;
            waddr_q <= waddr_d;
            w0_q    <= w0_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            oob_q   <= oob_d;
        end
    end

    assign busy        = (state_q != PRA_IDLE);
    assign packet_data = data_q;
    assign data_vld    = vld_q;
    assign oob         = oob_q;

endmodule

// File: tb/tb_packet_read_align.sv
// Directed self-checking bench for packet_read_align; word0=0x11223344, word1=0x55667788.
module tb_packet_read_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [1:0]  rd_size;
    logic [31:0] packet_len;
    logic        busy;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] packet_data;
    logic        data_vld;
    logic        oob;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:1023];

    packet_read_align #(.BYTE_ADDR_WIDTH(12), .PLEN_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_size     (rd_size),
        .packet_len  (packet_len),
        .busy        (busy),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .packet_data (packet_data),
        .data_vld    (data_vld),
        .oob         (oob)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rd_en = 1'b0;
        tick();
        tick();
        total += 6;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (data_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b expected 0", data_vld); end
        if (oob !== 1'b0) begin bad++; $display("FAIL reset_oob: got %b expected 0", oob); end
        if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_mem_rd_en: got %b expected 0", mem_rd_en); end
        if (mem_addr !== 10'd0) begin bad++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
        if (packet_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %08h expected 00000000", packet_data); end
        rst = 1'b0;
        tick();
        $display("reset: busy=%b vld=%b data=%08h", busy, data_vld, packet_data);
    endtask

    task automatic test_byte;
        rd_en = 1'b1; rd_addr = 12'd2; rd_size = 2'b00;
        #1;
        total += 2;
        if (mem_rd_en !== 1'b1) begin bad++; $display("FAIL byte_T_rd_en: got %b expected 1", mem_rd_en); end
        if (mem_addr !== 10'd0) begin bad++; $display("FAIL byte_T_addr: got %0d expected 0", mem_addr); end
        tick();
        rd_en = 1'b0;
        total += 2;
        if (data_vld !== 1'b0) begin bad++; $display("FAIL byte_T1_vld: got %b expected 0", data_vld); end
        if (busy !== 1'b1) begin bad++; $display("FAIL byte_T1_busy: got %b expected 1", busy); end
        tick();
        total += 3;
        if (data_vld !== 1'b1) begin bad++; $display("FAIL byte_T2_vld: got %b expected 1", data_vld); end
        if (packet_data !== 32'h00000033) begin bad++; $display("FAIL byte_T2_data: got %08h expected 00000033", packet_data); end
        if (busy !== 1'b0) begin bad++; $display("FAIL byte_T2_busy: got %b expected 0", busy); end
        $display("byte addr=2: data=%08h vld=%b", packet_data, data_vld);
        tick();
        total += 2;
        if (data_vld !== 1'b0) begin bad++; $display("FAIL byte_pulse_len: got %b expected 0", data_vld); end
        if (packet_data !== 32'h00000033) begin bad++; $display("FAIL byte_hold: got %08h expected 00000033", packet_data); end
    endtask

    task automatic test_half_straddle;
        rd_en = 1'b1; rd_addr = 12'd3; rd_size = 2'b01;
        #1;
        total += 2;
        if (mem_rd_en !== 1'b1) begin bad++; $display("FAIL half_T_rd_en: got %b expected 1", mem_rd_en); end
        if (mem_addr !== 10'd0) begin bad++; $display("FAIL half_T_addr: got %0d expected 0", mem_addr); end
        tick();
        rd_en = 1'b0;
        total += 3;
        if (mem_rd_en !== 1'b1) begin bad++; $display("FAIL half_T1_rd_en: got %b expected 1", mem_rd_en); end
        if (mem_addr !== 10'd1) begin bad++; $display("FAIL half_T1_addr: got %0d expected 1", mem_addr); end
        if (data_vld !== 1'b0) begin bad++; $display("FAIL half_T1_vld: got %b expected 0", data_vld); end
        tick();
        total += 2;
        if (data_vld !== 1'b0) begin bad++; $display("FAIL half_T2_vld: got %b expected 0", data_vld); end
        if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL half_T2_rd_en: got %b expected 0", mem_rd_en); end
        tick();
        total += 2;
        if (data_vld !== 1'b1) begin bad++; $display("FAIL half_T3_vld: got %b expected 1", data_vld); end
        if (packet_data !== 32'h00004455) begin bad++; $display("FAIL half_T3_data: got %08h expected 00004455", packet_data); end
        $display("half addr=3: data=%08h vld=%b", packet_data, data_vld);
        tick();
    endtask

    task automatic test_word;
        rd_en = 1'b1; rd_addr = 12'd4; rd_size = 2'b10;
        #1;
        total += 1;
        if (mem_addr !== 10'd1) begin bad++; $display("FAIL word4_T_addr: got %0d expected 1", mem_addr); end
        tick();
        rd_en = 1'b0;
        tick();
        total += 3;
        if (data_vld !== 1'b1) begin bad++; $display("FAIL word4_vld: got %b expected 1", data_vld); end
        if (packet_data !== 32'h55667788) begin bad++; $display("FAIL word4_data: got %08h expected 55667788", packet_data); end
        if (oob !== 1'b0) begin bad++; $display("FAIL word4_oob: got %b expected 0", oob); end
        $display("word addr=4: data=%08h vld=%b", packet_data, data_vld);
        tick();

        rd_en = 1'b1; rd_addr = 12'd1; rd_size = 2'b10;
        tick();
        rd_en = 1'b0;
        tick();
        total += 1;
        if (data_vld !== 1'b0) begin bad++; $display("FAIL word1_T2_vld: got %b expected 0", data_vld); end
        tick();
        total += 2;
        if (data_vld !== 1'b1) begin bad++; $display("FAIL word1_T3_vld: got %b expected 1", data_vld); end
        if (packet_data !== 32'h22334455) begin bad++; $display("FAIL word1_data: got %08h expected 22334455", packet_data); end
        $display("word addr=1: data=%08h vld=%b", packet_data, data_vld);
        tick();
    endtask

    task automatic test_bounds;
        packet_len = 32'd6;
        rd_en = 1'b1; rd_addr = 12'd4; rd_size = 2'b10;
        #1;
`ifdef PACKET_BOUNDS_CHECK_EN
        total += 1;
        if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL oob_T_rd_en: got %b expected 0", mem_rd_en); end
        tick();
        rd_en = 1'b0;
        total += 4;
        if (data_vld !== 1'b1) begin bad++; $display("FAIL oob_T1_vld: got %b expected 1", data_vld); end
        if (oob !== 1'b1) begin bad++; $display("FAIL oob_T1_oob: got %b expected 1", oob); end
        if (packet_data !== 32'h0) begin bad++; $display("FAIL oob_T1_data: got %08h expected 00000000", packet_data); end
        if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL oob_T1_rd_en: got %b expected 0", mem_rd_en); end
        $display("oob word addr=4 len=6: data=%08h oob=%b", packet_data, oob);
        tick();
        total += 3;
        if (data_vld !== 1'b0) begin bad++; $display("FAIL oob_T2_vld: got %b expected 0", data_vld); end
        if (oob !== 1'b0) begin bad++; $display("FAIL oob_T2_oob: got %b expected 0", oob); end
        if (busy !== 1'b0) begin bad++; $display("FAIL oob_T2_busy: got %b expected 0", busy); end
`else
        total += 1;
        if (mem_rd_en !== 1'b1) begin bad++; $display("FAIL nochk_T_rd_en: got %b expected 1", mem_rd_en); end
        tick();
        rd_en = 1'b0;
        tick();
        total += 3;
        if (data_vld !== 1'b1) begin bad++; $display("FAIL nochk_vld: got %b expected 1", data_vld); end
        if (packet_data !== 32'h55667788) begin bad++; $display("FAIL nochk_data: got %08h expected 55667788", packet_data); end
        if (oob !== 1'b0) begin bad++; $display("FAIL nochk_oob: got %b expected 0", oob); end
        $display("unchecked word addr=4 len=6: data=%08h oob=%b", packet_data, oob);
`endif
        tick();
        // Exactly at the end of the packet is still in bounds.
        packet_len = 32'd8;
        rd_en = 1'b1; rd_addr = 12'd4; rd_size = 2'b10;
        tick();
        rd_en = 1'b0;
        tick();
        total += 3;
        if (data_vld !== 1'b1) begin bad++; $display("FAIL edge_vld: got %b expected 1", data_vld); end
        if (packet_data !== 32'h55667788) begin bad++; $display("FAIL edge_data: got %08h expected 55667788", packet_data); end
        if (oob !== 1'b0) begin bad++; $display("FAIL edge_oob: got %b expected 0", oob); end
        $display("word addr=4 len=8: data=%08h oob=%b", packet_data, oob);
        packet_len = 32'd64;
        tick();
    endtask

    task automatic test_hold_busy;
        int vld_cnt;
        int rd_cnt;
        vld_cnt = 0;
        rd_cnt = 0;
        rd_en = 1'b1; rd_addr = 12'd0; rd_size = 2'b00;
        #1;
        if (mem_rd_en === 1'b1) rd_cnt++;
        tick();
        if (mem_rd_en === 1'b1) rd_cnt++;
        if (data_vld === 1'b1) vld_cnt++;
        rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_rd_en === 1'b1) rd_cnt++;
            if (data_vld === 1'b1) vld_cnt++;
        end
        total += 2;
        if (vld_cnt != 1) begin bad++; $display("FAIL hold_vld_count: got %0d expected 1", vld_cnt); end
        if (rd_cnt != 1) begin bad++; $display("FAIL hold_rd_count: got %0d expected 1", rd_cnt); end
        $display("held rd_en: vld pulses=%0d mem reads=%0d", vld_cnt, rd_cnt);
    endtask

    task automatic test_back_to_back;
        rd_en = 1'b1; rd_addr = 12'd0; rd_size = 2'b00;
        tick();
        rd_en = 1'b0;
        tick();
        total += 2;
        if (data_vld !== 1'b1) begin bad++; $display("FAIL b2b_first_vld: got %b expected 1", data_vld); end
        if (packet_data !== 32'h00000011) begin bad++; $display("FAIL b2b_first_data: got %08h expected 00000011", packet_data); end
        $display("b2b byte addr=0: data=%08h", packet_data);
        rd_en = 1'b1; rd_addr = 12'd1; rd_size = 2'b00;
        #1;
        total += 1;
        if (mem_rd_en !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b expected 1", mem_rd_en); end
        tick();
        rd_en = 1'b0;
        tick();
        total += 2;
        if (data_vld !== 1'b1) begin bad++; $display("FAIL b2b_second_vld: got %b expected 1", data_vld); end
        if (packet_data !== 32'h00000022) begin bad++; $display("FAIL b2b_second_data: got %08h expected 00000022", packet_data); end
        $display("b2b byte addr=1: data=%08h", packet_data);
        tick();
    endtask

    task automatic test_reset_mid;
        int vld_cnt;
        vld_cnt = 0;
        rd_en = 1'b1; rd_addr = 12'd1; rd_size = 2'b10;
        tick();
        rd_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total += 2;
        if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (data_vld !== 1'b0) begin bad++; $display("FAIL midrst_vld: got %b expected 0", data_vld); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (data_vld === 1'b1) vld_cnt++;
        end
        total += 1;
        if (vld_cnt != 0) begin bad++; $display("FAIL midrst_stray_vld: got %0d expected 0", vld_cnt); end
        rd_en = 1'b1; rd_addr = 12'd0; rd_size = 2'b00;
        tick();
        rd_en = 1'b0;
        tick();
        total += 2;
        if (data_vld !== 1'b1) begin bad++; $display("FAIL midrst_after_vld: got %b expected 1", data_vld); end
        if (packet_data !== 32'h00000011) begin bad++; $display("FAIL midrst_after_data: got %08h expected 00000011", packet_data); end
        $display("after mid reset byte addr=0: data=%08h", packet_data);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h11223344;
        mem[1] = 32'h55667788;
        mem_rdata  = 32'h0;
        rst        = 1'b1;
        rd_en      = 1'b0;
        rd_addr    = 12'd0;
        rd_size    = 2'b00;
        packet_len = 32'd64;
        #1;
        test_reset();
        test_byte();
        test_half_straddle();
        test_word();
        test_bounds();
        test_hold_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
